key_debounce_multi: RTL and testbench

Parametrised N-channel push-button debouncer with per-channel LED control, successor to the fixed 3-key toggle debouncer. Each channel has its own two-flop synchroniser, its own stability counter, and its own press/release pulse outputs. An LED mode is selectable per build: toggle on press, follow the debounced level, or one-shot pulse stretch. Sits between raw board key pins and LED/user logic on the 50 MHz board clock.

---
 rtl/key_debounce_multi_if.sv | 31 +++
 rtl/key_debounce_multi.sv | 167 ++++++++++++++++
 tb/tb_key_debounce_multi.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_multi_if.sv
// Key/LED signal bundle between raw board keys, the debouncer and user logic.
interface key_debounce_multi_if #(
  parameter int unsigned N_KEYS = 3
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] led;
  logic [N_KEYS-1:0] led_clr;

  // Board/user side: drives raw keys and LED clears, observes debounced results.
  modport master (
    output key_in,
    output led_clr,
    input  key_level,
    input  key_press,
    input  key_release,
    input  led
  );

  // Debouncer side.
  modport slave (
    input  key_in,
    input  led_clr,
    output key_level,
    output key_press,
    output key_release,
    output led
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: per-channel two-flop synchroniser,
// stability-counter FSM, press/release pulses and a build-time LED mode
// (0 = toggle on press, 1 = follow level, 2 = pulse stretch).
module key_debounce_multi #(
  parameter int unsigned N_KEYS         = 3,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned DEBOUNCE_CYC   = 'hF423F,
  parameter int unsigned LED_MODE       = 0,
  parameter int unsigned STRETCH_CYC    = 25000000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_debounce_multi_if.slave   bus
);

  localparam int unsigned STR_W = CNT_W + 6;

  // Acceptance happens on the edge that brings the counter to DEBOUNCE_CYC-1,
  // i.e. when the registered count still reads DEBOUNCE_CYC-2. Together with the
  // entry cycle this gives exactly DEBOUNCE_CYC stable samples of sync.
  localparam logic [CNT_W-1:0] ACCEPT_AT    = CNT_W'(DEBOUNCE_CYC - 32'd2);
  localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_CYC);
  localparam logic [N_KEYS-1:0] REL_RAW     = KEY_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE_REL,
    WAIT_PRS,
    IDLE_PRS,
    WAIT_REL
  } state_t;

  logic [N_KEYS-1:0] meta_q;
  logic [N_KEYS-1:0] sync_q;
  logic [N_KEYS-1:0] sync;

  state_t            state_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] rel_q;
  logic [N_KEYS-1:0] acc_press;
  logic [N_KEYS-1:0] acc_rel;

  logic [N_KEYS-1:0] tog_q;
  logic [STR_W-1:0]  str_q   [N_KEYS];
  logic [N_KEYS-1:0] str_on;
  logic [N_KEYS-1:0] led_w;

  // Two-flop synchroniser; resets to the released raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= REL_RAW;
      sync_q <= REL_RAW;
    end else begin
      meta_q <= bus.key_in;
      sync_q <= meta_q;
    end
  end

  assign sync = KEY_ACTIVE_LOW ? ~sync_q : sync_q;

  // Per-channel acceptance strobes, shared by the FSM and the LED logic.
  always_comb begin
    acc_press = '0;
    acc_rel   = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      acc_press[i] = (state_q[i] == WAIT_PRS) && sync[i]  && (cnt_q[i] == ACCEPT_AT);
      acc_rel[i]   = (state_q[i] == WAIT_REL) && !sync[i] && (cnt_q[i] == ACCEPT_AT);
    end
  end

  // Debounce FSM per channel with registered level and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE_REL;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      press_q <= acc_press;
      rel_q   <= acc_rel;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        unique case (state_q[i])
          IDLE_REL: begin
            if (sync[i]) begin
              state_q[i] <= WAIT_PRS;
              cnt_q[i]   <= '0;
            end
          end
          WAIT_PRS: begin
            if (!sync[i]) begin
              state_q[i] <= IDLE_REL;
            end else if (acc_press[i]) begin
              state_q[i] <= IDLE_PRS;
              level_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          IDLE_PRS: begin
            if (!sync[i]) begin
              state_q[i] <= WAIT_REL;
              cnt_q[i]   <= '0;
            end
          end
          WAIT_REL: begin
            if (sync[i]) begin
              state_q[i] <= IDLE_PRS;
            end else if (acc_rel[i]) begin
              state_q[i] <= IDLE_REL;
              level_q[i] <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          default: state_q[i] <= IDLE_REL;
        endcase
      end
    end
  end

  // Toggle bit and stretch counter; led_clr has priority over a same-cycle press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        str_q[i] <= '0;
      end
    end else begin
      tog_q <= (tog_q ^ acc_press) & ~bus.led_clr;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (bus.led_clr[i]) begin
          str_q[i] <= '0;
        end else if (acc_press[i]) begin
          str_q[i] <= STRETCH_LOAD;
        end else if (str_q[i] != '0) begin
          str_q[i] <= str_q[i] - STR_W'(1);
        end
      end
    end
  end

  // LED source selected by build mode; unused sources are pruned in synthesis.
  always_comb begin
    str_on = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      str_on[i] = (str_q[i] != '0);
    end
    if (LED_MODE == 1) begin
      led_w = level_q;
    end else if (LED_MODE == 2) begin
      led_w = str_on;
    end else begin
      led_w = tog_q;
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;
  assign bus.led         = led_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: toggle-mode instance (dut0) and
// pulse-stretch instance (dut2), both with a 16-cycle debounce window.
module tb_key_debounce_multi;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  key_debounce_multi_if #(.N_KEYS(3)) if0 ();
  key_debounce_multi_if #(.N_KEYS(3)) if2 ();

  key_debounce_multi #(
    .N_KEYS(3), .CNT_W(20), .DEBOUNCE_CYC(16), .LED_MODE(0),
    .STRETCH_CYC(100), .KEY_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  key_debounce_multi #(
    .N_KEYS(3), .CNT_W(20), .DEBOUNCE_CYC(16), .LED_MODE(2),
    .STRETCH_CYC(100), .KEY_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 dut0 press, 1 dut0 release, 2 dut2 press, 3 dut2 release.
  // Returns cycles until the first nonzero pulse (bounded) and its value.
  task automatic wait_pulse(input int sel, output int n, output logic [2:0] v);
    n = 0;
    v = '0;
    while (n < 100) begin
      tick();
      n++;
      case (sel)
        0:       v = if0.key_press;
        1:       v = if0.key_release;
        2:       v = if2.key_press;
        default: v = if2.key_release;
      endcase
      if (v != 3'b000) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int         n;
    logic [2:0] v;
    int         stray;

    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    if0.key_in  = 3'b111;
    if0.led_clr = 3'b000;
    if2.key_in  = 3'b111;
    if2.led_clr = 3'b000;

    // Reset state
    tick();
    tick();
    chk("rst_level", 32'(if0.key_level), 32'h0);
    chk("rst_press", 32'(if0.key_press), 32'h0);
    chk("rst_rel",   32'(if0.key_release), 32'h0);
    chk("rst_led0",  32'(if0.led), 32'h0);
    chk("rst_led2",  32'(if2.led), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // 1: clean press on key 0
    if0.key_in = 3'b110;
    wait_pulse(0, n, v);
    chk("t1_lat",   32'(n), 32'd18);
    chk("t1_press", 32'(v), 32'h1);
    chk("t1_level", 32'(if0.key_level), 32'h1);
    chk("t1_led",   32'(if0.led), 32'h1);
    tick();
    chk("t1_pulse_end", 32'(if0.key_press), 32'h0);

    // 2: bounce on key 1 for 60 cycles, then hold pressed
    stray = 0;
    for (int s = 0; s < 12; s++) begin
      if0.key_in[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (if0.key_press != 3'b000 || if0.key_release != 3'b000) stray++;
      end
    end
    chk("t2_no_pulse", 32'(stray), 32'd0);
    chk("t2_level_mid", 32'(if0.key_level), 32'h1);
    if0.key_in[1] = 1'b0;
    wait_pulse(0, n, v);
    chk("t2_lat",   32'(n), 32'd18);
    chk("t2_press", 32'(v), 32'h2);
    chk("t2_led",   32'(if0.led), 32'h3);

    // 3: release key 0, then press again (toggles led 0 back off)
    if0.key_in[0] = 1'b1;
    wait_pulse(1, n, v);
    chk("t3_rel_lat", 32'(n), 32'd18);
    chk("t3_rel",     32'(v), 32'h1);
    chk("t3_level",   32'(if0.key_level), 32'h2);
    tick();
    chk("t3_rel_end", 32'(if0.key_release), 32'h0);
    if0.key_in[0] = 1'b0;
    wait_pulse(0, n, v);
    chk("t3_prs_lat", 32'(n), 32'd18);
    chk("t3_led",     32'(if0.led), 32'h2);

    // 5: stretch mode, retrigger 50 cycles after the first press
    if2.key_in[0] = 1'b0;
    wait_pulse(2, n, v);
    chk("t5_lat", 32'(n), 32'd18);
    chk("t5_led", 32'(if2.led), 32'h1);
    repeat (10) tick();
    if2.key_in[0] = 1'b1;
    wait_pulse(3, n, v);
    chk("t5_rel_lat", 32'(n), 32'd18);
    repeat (4) tick();
    if2.key_in[0] = 1'b0;
    wait_pulse(2, n, v);
    chk("t5_retrig_lat", 32'(n), 32'd18);
    chk("t5_led_retrig", 32'(if2.led), 32'h1);
    repeat (99) tick();
    chk("t5_led_last_on", 32'(if2.led), 32'h1);
    tick();
    chk("t5_led_off", 32'(if2.led), 32'h0);
    // led_clr on the same cycle as the accepted press
    if2.key_in[0] = 1'b1;
    wait_pulse(3, n, v);
    if2.key_in[0] = 1'b0;
    repeat (17) tick();
    if2.led_clr = 3'b001;
    tick();
    if2.led_clr = 3'b000;
    chk("t5_clr_press", 32'(if2.key_press), 32'h1);
    chk("t5_clr_led",   32'(if2.led), 32'h0);
    tick();
    chk("t5_clr_led_hold", 32'(if2.led), 32'h0);

    // 4: release keys 0 and 1 together, reset, then press all three at once
    if0.key_in = 3'b111;
    wait_pulse(1, n, v);
    chk("t4_rel_lat", 32'(n), 32'd18);
    chk("t4_rel",     32'(v), 32'h3);
    do_reset();
    if0.key_in = 3'b000;
    wait_pulse(0, n, v);
    chk("t4_lat",   32'(n), 32'd18);
    chk("t4_press", 32'(v), 32'h7);
    chk("t4_led",   32'(if0.led), 32'h7);

    // 6: reset mid-debounce with key 2 held
    if0.key_in = 3'b111;
    wait_pulse(1, n, v);
    chk("t6_rel", 32'(v), 32'h7);
    if0.key_in = 3'b011;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_led",   32'(if0.led), 32'h0);
    chk("t6_rst_level", 32'(if0.key_level), 32'h0);
    chk("t6_rst_press", 32'(if0.key_press), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_pulse(0, n, v);
    chk("t6_lat",   32'(n), 32'd18);
    chk("t6_press", 32'(v), 32'h4);
    chk("t6_led",   32'(if0.led), 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
